// File: rtl/seg_scan_controller_pkg.sv
// Shared types and constants for the multiplexed seven-segment scan controller.
// Holds the slot FSM encoding and the threshold above which a BCD value is blanked.
package seg_scan_controller_pkg;

    typedef enum logic {
        GAP = 1'b0,
        ON  = 1'b1
    } scan_state_t;

    localparam logic [3:0] BCD_BLANK_MIN = 4'd10;

    // Values of ten and above have no decimal glyph, so their slot stays dark.
    function automatic logic is_blank_value(input logic [3:0] value);
        return value >= BCD_BLANK_MIN;
    endfunction

endpackage

// File: rtl/seg_scan_controller_decoder.sv
// BCD to seven-segment decoder shared by all digits of the scan controller.
// seg is {g,f,e,d,c,b,a}, active-high; non-decimal codes give a dark pattern.
module sevenSegmentDecoder (
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'h00;
        case (bcd)
            4'd0:    seg = 7'h3F;
            4'd1:    seg = 7'h06;
            4'd2:    seg = 7'h5B;
            4'd3:    seg = 7'h4F;
            4'd4:    seg = 7'h66;
            4'd5:    seg = 7'h6D;
            4'd6:    seg = 7'h7D;
            4'd7:    seg = 7'h07;
            4'd8:    seg = 7'h7F;
            4'd9:    seg = 7'h6F;
            default: seg = 7'h00;
        endcase
    end

endmodule

// File: rtl/seg_scan_controller.sv
// Time-multiplexed seven-segment scan controller with tear-free double-buffered digits.
// Define SEG_LZ_SUPPRESS_EN to blank leading zeros (digit 0 is always shown).
module seg_scan_controller
    import seg_scan_controller_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int SLOT_CYCLES = 1000,
    parameter int GAP_CYCLES  = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   digits_i,
    output logic [3:0]                bcd,
    output logic [6:0]                seg,
    output logic [NUM_DIGITS-1:0]     an,
    output logic                      frame_done,
    output logic                      pending
);

    localparam int DW = 4 * NUM_DIGITS;
    localparam int CW = $clog2(SLOT_CYCLES);
    localparam int IW = $clog2(NUM_DIGITS);

    localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT_CYCLES - 1);
    localparam logic [CW-1:0] GAP_END   = CW'(GAP_CYCLES);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

    logic [CW-1:0]         count_reg, count_next;
    logic [IW-1:0]         idx_reg, idx_next;
    scan_state_t           state_reg, state_next;
    logic [3:0]            bcd_reg, bcd_next;
    logic [NUM_DIGITS-1:0] an_reg, an_next;
    logic                  frame_done_reg, frame_done_next;
    logic [DW-1:0]         active_reg, active_next;
    logic [DW-1:0]         shadow_reg, shadow_next;
    logic                  pending_reg, pending_next;

    logic                  slot_end;
    logic                  frame_wrap;
    logic [3:0]            digit_next [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] digit_blank;
    logic                  blank_next;

    // Slot timing: counter, digit index and frame wrap detection.
    always_comb begin
        slot_end   = (count_reg == SLOT_LAST);
        frame_wrap = slot_end && (idx_reg == IDX_LAST);
        count_next = slot_end ? '0 : count_reg + 1'b1;
        idx_next   = idx_reg;
        if (slot_end) begin
            idx_next = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
        end
        frame_done_next = frame_wrap;
    end

    // Each slot opens with a dark gap so the previous digit's segments settle.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            GAP:     state_next = (count_next >= GAP_END) ? ON : GAP;
            ON:      state_next = slot_end ? GAP : ON;
            default: state_next = GAP;
        endcase
    end

    // Double buffer: the displayed value only moves at the frame wrap, and a
    // load on the wrap edge itself bypasses the shadow so the newest value wins.
    always_comb begin
        shadow_next  = load ? digits_i : shadow_reg;
        active_next  = active_reg;
        pending_next = pending_reg;
        if (frame_wrap) begin
            pending_next = 1'b0;
            if (load) begin
                active_next = digits_i;
            end else if (pending_reg) begin
                active_next = shadow_reg;
            end
        end else if (load) begin
            pending_next = 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign digit_next[gi] = active_next[4*gi +: 4];
`ifdef SEG_LZ_SUPPRESS_EN
            assign digit_blank[gi] = is_blank_value(digit_next[gi])
                                   || ((gi != 0) && (active_next[DW-1:4*gi] == '0));
`else
            assign digit_blank[gi] = is_blank_value(digit_next[gi]);
`endif
            assign an_next[gi] = ~((state_next == ON) && (idx_next == IW'(gi)) && !blank_next);
        end
    endgenerate

    assign bcd_next   = digit_next[idx_next];
    assign blank_next = digit_blank[idx_next];

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg      <= '0;
            idx_reg        <= '0;
            state_reg      <= GAP;
            bcd_reg        <= '0;
            an_reg         <= '1;
            frame_done_reg <= 1'b0;
            active_reg     <= '0;
            shadow_reg     <= '0;
            pending_reg    <= 1'b0;
        end else begin
            count_reg      <= count_next;
            idx_reg        <= idx_next;
            state_reg      <= state_next;
            bcd_reg        <= bcd_next;
            an_reg         <= an_next;
            frame_done_reg <= frame_done_next;
            active_reg     <= active_next;
            shadow_reg     <= shadow_next;
            pending_reg    <= pending_next;
        end
    end

    sevenSegmentDecoder u_decoder (
        .bcd (bcd_reg),
        .seg (seg)
    );

    assign bcd        = bcd_reg;
    assign an         = an_reg;
    assign frame_done = frame_done_reg;
    assign pending    = pending_reg;

endmodule

// File: tb/tb_seg_scan_controller.sv
// Scoreboard bench for seg_scan_controller (4 digits, 8-cycle slots, 2-cycle gap).
// Stimulus pushes the expected display state per cycle; a monitor pops and compares.
module tb_seg_scan_controller;

    localparam int ND    = 4;
    localparam int SC    = 8;
    localparam int GC    = 2;
    localparam int FRAME = ND * SC;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] digits_i = 16'h0000;
    logic [3:0]  bcd;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_done;
    logic        pending;

    seg_scan_controller #(
        .NUM_DIGITS  (ND),
        .SLOT_CYCLES (SC),
        .GAP_CYCLES  (GC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .digits_i   (digits_i),
        .bcd        (bcd),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         at_cyc;
        int         t;
        logic [3:0] an;
        logic [3:0] bcd;
        logic       fd;
        logic       pend;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    bit   done = 1'b0;

    int          f0 = 0;
    int          cur_t = 0;
    logic [15:0] exp_shown = 16'h0000;
    logic [15:0] exp_next = 16'h0000;
    logic        exp_pend = 1'b0;

    function automatic logic [6:0] seg_ref(input logic [3:0] d);
        case (d)
            4'd0: return 7'h3F;
            4'd1: return 7'h06;
            4'd2: return 7'h5B;
            4'd3: return 7'h4F;
            4'd4: return 7'h66;
            4'd5: return 7'h6D;
            4'd6: return 7'h7D;
            4'd7: return 7'h07;
            4'd8: return 7'h7F;
            4'd9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    function automatic logic blank_ref(input logic [15:0] v, input int slot);
        logic [3:0] d;
        d = v[slot*4 +: 4];
        if (d > 4'd9) return 1'b1;
`ifdef SEG_LZ_SUPPRESS_EN
        if (slot > 0 && (v >> (4*slot)) == 16'h0000) return 1'b1;
`endif
        return 1'b0;
    endfunction

    task automatic push_exp();
        exp_t e;
        int   slot;
        int   cnt;
        slot     = (cur_t / SC) % ND;
        cnt      = cur_t % SC;
        e.at_cyc = cyc;
        e.t      = cur_t;
        e.bcd    = exp_shown[slot*4 +: 4];
        e.an     = 4'hF;
        if (cnt >= GC && !blank_ref(exp_shown, slot)) e.an[slot] = 1'b0;
        e.fd     = (cur_t > 0) && (cur_t % FRAME == 0);
        e.pend   = exp_pend;
        sb.push_back(e);
    endtask

    task automatic cycle();
        @(posedge clk);
        #2;
        load  = 1'b0;
        cur_t = cyc - f0;
        if (cur_t > 0 && cur_t % FRAME == 0) begin
            exp_shown = exp_next;
            exp_pend  = 1'b0;
        end
        push_exp();
    endtask

    task automatic run_to(input int tt);
        while (cur_t < tt) cycle();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #2;
        end
        rst       = 1'b0;
        load      = 1'b0;
        f0        = cyc;
        cur_t     = 0;
        exp_shown = 16'h0000;
        exp_next  = 16'h0000;
        exp_pend  = 1'b0;
        push_exp();
        $display("reset released at cycle %0d", cyc);
    endtask

    task automatic do_load(input logic [15:0] v);
        load     = 1'b1;
        digits_i = v;
        exp_pend = 1'b1;
        exp_next = v;
        $display("load %04h at t=%0d (slot %0d count %0d)", v, cur_t, (cur_t / SC) % ND, cur_t % SC);
        cycle();
    endtask

    task automatic chk(input string nm, input int t, input logic [7:0] act, input logic [7:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s t=%0d got %0h want %0h", nm, t, act, want);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                checks++;
                if ($countones(~an) > 1) begin
                    errors++;
                    $display("FAIL an_onehot cycle=%0d got %b want at most one low", cyc, an);
                end
            end
            while (sb.size() > 0 && sb[0].at_cyc <= cyc) begin
                mon_e = sb.pop_front();
                if (mon_e.at_cyc < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL stale_entry t=%0d got cycle %0d want cycle %0d", mon_e.t, cyc, mon_e.at_cyc);
                end else begin
                    chk("an", mon_e.t, {4'b0, an}, {4'b0, mon_e.an});
                    chk("bcd", mon_e.t, {4'b0, bcd}, {4'b0, mon_e.bcd});
                    chk("frame_done", mon_e.t, {7'b0, frame_done}, {7'b0, mon_e.fd});
                    chk("pending", mon_e.t, {7'b0, pending}, {7'b0, mon_e.pend});
                    if (mon_e.bcd <= 4'd9) chk("seg", mon_e.t, {1'b0, seg}, {1'b0, seg_ref(mon_e.bcd)});
                end
            end
            if (done) begin
                checks++;
                if (sb.size() != 0) begin
                    errors++;
                    $display("FAIL scoreboard_drain got %0d left want 0", sb.size());
                end
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $finish;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        do_reset(3);
        run_to(64);
        run_to(70);
        do_load(16'h1259);
        run_to(127);
        run_to(130);
        do_load(16'h1111);
        run_to(140);
        do_load(16'h2222);
        run_to(191);
        run_to(223);
        do_load(16'h0000);
        run_to(235);
        do_load(16'h00F7);
        run_to(287);
        run_to(291);
        do_load(16'h4321);
        run_to(309);
        load     = 1'b1;
        digits_i = 16'h9999;
        $display("reset with load 9999 at t=%0d (slot %0d count %0d)", cur_t, (cur_t / SC) % ND, cur_t % SC);
        do_reset(1);
        run_to(70);
        done = 1'b1;
    end

endmodule

// File: doc/seg_scan_controller.md
SEG_SCAN_CONTROLLER -- requirements
Module: seg_scan_controller

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of multiplexed digits (2..8).
REQ-002 Parameter SLOT_CYCLES, default 1000, clock cycles per digit slot (≥ GAP_CYCLES+2).
REQ-003 Parameter GAP_CYCLES, default 2, all-anodes-off cycles at the start of each slot (anti-ghosting, ≥1).
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 load  input  1  one-cycle strobe; capture digits_i.
REQ-007 digits_i  input  4*NUM_DIGITS  packed BCD; digit 0 in bits [3:0].
REQ-008 bcd  output  4  BCD of current digit, fed to the shared decoder.
REQ-009 seg  output  7  segment pattern from the decoder for bcd.
REQ-010 an  output  NUM_DIGITS  active-low anode enables; at most one bit low.
REQ-011 frame_done  output  1  one-cycle pulse at frame wrap.
REQ-012 pending  output  1  high while a loaded value awaits frame wrap.

Function
REQ-013 FSM states GAP and ON; every slot begins in GAP.
REQ-014 Slot counter counts 0..SLOT_CYCLES-1; GAP while count < GAP_CYCLES, ON otherwise.
REQ-015 In GAP: an all ones; bcd holds the current digit value.
REQ-016 In ON: an bit [idx] low, all other bits high.
REQ-017 At count = SLOT_CYCLES-1: count -> 0, state -> GAP, idx -> idx+1; idx wraps NUM_DIGITS-1 -> 0.
REQ-018 frame_done is high for exactly the cycle after idx wraps to 0 (the first GAP cycle of digit 0).
REQ-019 bcd = active[idx], registered, updated the same cycle as idx.
REQ-020 A digit value >9 is blanked: an stays all ones for that slot; timing is unchanged.
REQ-021 load captures digits_i into a shadow register and sets pending; a later load before wrap overwrites shadow.
REQ-022 At the wrap edge with pending=1: active <= shadow, pending -> 0.
REQ-023 load on the wrap edge itself: active <= digits_i directly, pending -> 0 (newest value wins).
REQ-024 active never changes except at wrap, so no partial frame (tearing) is ever displayed.
REQ-025 seg is combinational from bcd through the decoder; no extra latency.

Reset
REQ-026 rst: count=0, idx=0, state=GAP, an=all ones, bcd=0, active=0, shadow=0, pending=0, frame_done=0.
REQ-027 rst mid-slot or mid-frame discards the shadow value and restarts at digit 0 GAP on the next cycle.
REQ-028 rst dominates load in the same cycle.

Configuration
REQ-029 Macro SEG_LZ_SUPPRESS_EN defined: leading zeros are blanked.
  - Leading zeros are zero digits above the most significant non-zero digit.
  - Digit 0 is never suppressed, so an all-zero value still shows one "0".
REQ-030 Macro SEG_LZ_SUPPRESS_EN undefined: all digits ≤9 are displayed, including leading zeros.

Structure
REQ-031 Shared package holds the state enum (GAP, ON) and the BCD_BLANK_MIN=10 constant.
REQ-032 One sub-module: the existing sevenSegmentDecoder, instantiated once with bcd -> seg, time-shared across digits.
REQ-033 No other sub-modules; slot counter, FSM and registers are local.

Verification (NUM_DIGITS=4, SLOT_CYCLES=8, GAP_CYCLES=2)
REQ-034 Reset then idle 32 cycles:
  - an sequence per slot: 1111,1111,1110x6; then 1111,1111,1101x6; and so on.
  - frame_done pulses every 32 cycles.
REQ-035 load digits_i=16'h1259 mid-frame:
  - pending=1 until wrap.
  - After wrap, bcd reads 9,5,2,1 for idx 0..3; seg for 9 equals the decoder output for 9.
REQ-036 Two loads in one frame (16'h1111, then 16'h2222): the next frame shows 2,2,2,2 only.
REQ-037 load 16'h0000 on the wrap cycle: active=0 immediately, pending stays 0.
REQ-038 Blank and suppression:
  - load 16'h00F7: digit 1 (value 15) stays blanked (an=1111) for its slot.
  - With SEG_LZ_SUPPRESS_EN, digits 2 and 3 are also blanked.
  - Without SEG_LZ_SUPPRESS_EN, digits 2 and 3 show 0.
REQ-039 rst asserted at idx=2, count=5 with pending=1: next cycle idx=0, an=1111, pending=0, active=0.
